// File: rtl/write_buffer.sv
// Posted-write FIFO between the data cache and data memory: absorbs stores, drains them
// one multi-cycle write at a time, and serves refill reads by forwarding or a memory read.
module write_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          WB_WR_REQ,
    input  logic [AW-1:0] WB_WR_ADDR,
    input  logic [DW-1:0] WB_WR_DATA,
    output logic          WB_FULL,
    output logic          WB_EMPTY,
    input  logic          WB_RD_REQ,
    input  logic [AW-1:0] WB_RD_ADDR,
    output logic [DW-1:0] WB_RD_DATA,
    output logic          WB_RD_VALID,
    output logic          D_MEM_CSN,
    output logic          D_MEM_WEN,
    output logic [AW-1:0] D_MEM_ADDR,
    output logic [DW-1:0] D_MEM_DI,
    input  logic [DW-1:0] D_MEM_DOUT
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          csn_q, csn_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mdi_q, mdi_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;

    logic [AW-1:0] ent_addr_q [DEPTH];
    logic [DW-1:0] ent_data_q [DEPTH];

    logic          push;
    logic          pop;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] idx;

    assign WB_FULL     = (count_q == CW'(DEPTH));
    assign WB_EMPTY    = (count_q == '0);
    assign push        = WB_WR_REQ && !WB_FULL;

    assign WB_RD_DATA  = rdata_q;
    assign WB_RD_VALID = rvalid_q;
    assign D_MEM_CSN   = csn_q;
    assign D_MEM_WEN   = wen_q;
    assign D_MEM_ADDR  = maddr_q;
    assign D_MEM_DI    = mdi_q;

    // Scan oldest to newest so the newest match wins; a same-cycle push overrides all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (ent_addr_q[idx] == WB_RD_ADDR)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[idx];
            end
        end
        if (push && (WB_WR_ADDR == WB_RD_ADDR)) begin
            fwd_hit  = 1'b1;
            fwd_data = WB_WR_DATA;
        end
    end

    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        lat_d    = lat_q;
        csn_d    = csn_q;
        wen_d    = wen_q;
        maddr_d  = maddr_q;
        mdi_d    = mdi_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (WB_RD_REQ) begin
                    if (fwd_hit) begin
                        rdata_d  = fwd_data;
                        rvalid_d = 1'b1;
                    end else begin
                        csn_d   = 1'b0;
                        wen_d   = 1'b1;
                        maddr_d = WB_RD_ADDR;
                        state_d = READ;
                    end
                end else if (!WB_EMPTY) begin
                    csn_d   = 1'b0;
                    wen_d   = 1'b0;
                    maddr_d = ent_addr_q[head_q];
                    mdi_d   = ent_data_q[head_q];
                    lat_d   = LW'(MEM_LAT - 1);
                    state_d = WRITE;
                end else begin
                    csn_d = 1'b1;
                    wen_d = 1'b1;
                end
            end
            WRITE: begin
                // The in-flight entry stays forwardable until its pop here.
                if (lat_q == '0) begin
                    pop     = 1'b1;
                    csn_d   = 1'b1;
                    wen_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            READ: begin
                csn_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rdata_d  = D_MEM_DOUT;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) tail_d = tail_q + PW'(1);
        if (pop)  head_d = head_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            lat_q    <= '0;
            csn_q    <= 1'b1;
            wen_q    <= 1'b1;
            maddr_q  <= '0;
            mdi_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            lat_q    <= lat_d;
            csn_q    <= csn_d;
            wen_q    <= wen_d;
            maddr_q  <= maddr_d;
            mdi_q    <= mdi_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Entry storage needs no reset: validity is carried entirely by count/head.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr_q[tail_q] <= WB_WR_ADDR;
            ent_data_q[tail_q] <= WB_WR_DATA;
        end
    end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write FIFO between the data cache's write-through/refill port and the data memory.
- Absorbs cache stores without stalling and drains them to memory in the background, one multi-cycle write at a time.
- Services cache refill reads by forwarding from buffered stores, or by issuing a single memory read.
- Keeps loads coherent with stores that have not yet drained.

Parameters:
- DEPTH, 4, number of buffered store entries (power of two, at least 2).
- AW, 12, address width; matches the data-memory word address.
- DW, 32, data width.
- MEM_LAT, 4, cycles a memory write is held on the memory bus (at least 1).

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- WB_WR_REQ  in  1  store push request from the cache.
- WB_WR_ADDR  in  AW  store address.
- WB_WR_DATA  in  DW  store data.
- WB_FULL  out  1  buffer full; a push is not accepted while high.
- WB_EMPTY  out  1  no buffered entries.
- WB_RD_REQ  in  1  refill read request; held high by the requester until WB_RD_VALID.
- WB_RD_ADDR  in  AW  read address; stable while WB_RD_REQ is high.
- WB_RD_DATA  out  DW  read data; valid when WB_RD_VALID is high.
- WB_RD_VALID  out  1  one-cycle read-complete pulse.
- D_MEM_CSN  out  1  memory chip select, active low.
- D_MEM_WEN  out  1  memory write enable, active low (1 = read).
- D_MEM_ADDR  out  AW  memory address.
- D_MEM_DI  out  DW  memory write data.
- D_MEM_DOUT  in  DW  memory read data, valid the cycle after a read is presented.

Behaviour:
- Reset (RSTn low, asynchronous):
  - head, tail and count = 0; state IDLE; MEM_LAT counter = 0.
  - D_MEM_CSN = 1, D_MEM_WEN = 1, D_MEM_ADDR = 0, D_MEM_DI = 0.
  - WB_RD_DATA = 0, WB_RD_VALID = 0, WB_FULL = 0, WB_EMPTY = 1.
  - Reset mid-write or mid-read aborts the operation; all buffered entries are discarded.
- Flags: WB_FULL = (count == DEPTH) and WB_EMPTY = (count == 0), both decoded from the registered count.
- Push:
  - Accepted on the rising edge when WB_WR_REQ && !WB_FULL: entry[tail] gets {addr, data}; tail wraps modulo DEPTH.
  - A push while WB_FULL is high is ignored, and the requester must hold it.
  - If the full buffer pops in the same cycle, the push is still rejected, because WB_FULL is the registered value.
  - Push and pop in the same cycle leave count unchanged.
- All memory-side outputs are registered.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE, WB_RD_REQ high (reads take priority over draining):
  - Search valid entries from newest (tail-1) to oldest.
  - A same-cycle push with WB_WR_ADDR == WB_RD_ADDR is the newest candidate and its data is forwarded directly (bypass).
  - Hit: WB_RD_DATA = newest matching data and WB_RD_VALID = 1 on the next edge. State stays IDLE, and the next state decision is made one cycle later.
  - Miss: register D_MEM_CSN = 0, D_MEM_WEN = 1, D_MEM_ADDR = WB_RD_ADDR, then go to READ.
- IDLE, no read, count > 0:
  - Register D_MEM_CSN = 0, D_MEM_WEN = 0, D_MEM_ADDR/D_MEM_DI = entry[head].
  - Load the counter with MEM_LAT-1 and go to WRITE.
- IDLE, otherwise: CSN = 1, WEN = 1.
- WRITE:
  - Hold the bus and decrement the counter.
  - When the counter is 0: pop the head (head wraps), set CSN = 1 and WEN = 1, go to IDLE.
  - Total bus occupancy is exactly MEM_LAT cycles.
  - A write in progress is never preempted. A read request waits, and the in-flight entry stays in the buffer (forwardable) until its pop.
- READ: set CSN = 1, go to RESP.
- RESP: WB_RD_DATA = D_MEM_DOUT, pulse WB_RD_VALID, go to IDLE.
- Read latency, request to VALID:
  - 1 cycle on a hit.
  - 3 cycles on a miss from IDLE.
  - Plus the remaining WRITE cycles if a drain is in progress.
- WB_RD_VALID is high for exactly one cycle per request. A request still high the cycle after VALID is treated as a new request.
- Only the newest matching entry is forwarded; older duplicates still drain in order. Memory write order equals push order.

Test Plan:
- Reset then 3 pushes (0x010/0xA, 0x020/0xB, 0x030/0xC), no reads -> memory writes in order, each CSN=0/WEN=0 for 4 cycles; WB_EMPTY=1 after 12 drain cycles.
- 5 back-to-back pushes, DEPTH=4, drain blocked by a held read -> WB_FULL=1 after the 4th push; the 5th is ignored until the requester re-presents it after a pop.
- Push 0x040/0x1111 then 0x040/0x2222, read 0x040 -> WB_RD_DATA=0x2222, VALID 1 cycle after the request; both writes still reach memory in order.
- Same-cycle push 0x050/0xBEEF and read 0x050 -> WB_RD_DATA=0xBEEF via bypass, with no memory read.
- Read 0x060 (not buffered, memory holds 0x600D) during an active drain -> the read waits for the write to finish, then VALID 3 cycles later with 0x600D.
- RSTn low during a WRITE with 2 entries buffered -> CSN=1, WEN=1 immediately, WB_EMPTY=1, WB_RD_VALID=0, no further memory writes.
